// File: rtl/block_delay_line.sv
// block_delay_line: multi-entry bundled-data delay line with four-phase
// dreq/dack handshakes on both sides. Tokens are captured into a circular
// buffer, each held for at least its captured delay_cfg cycles, and then
// re-issued downstream in strict FIFO order.
//
// Handshake semantics (both sides, four-phase return-to-zero):
//   upstream   : dreq_in rises with data_in stable -> dack_out rises on capture;
//                dreq_in falls -> dack_out falls. A full buffer withholds dack_out.
//   downstream : dreq_out rises with data_out valid -> dack_in rises -> dreq_out
//                falls and the entry is popped -> dack_in falls -> next token may
//                be presented.
module block_delay_line #(
    parameter int DATA_WIDTH  = 3,
    parameter int DEPTH       = 4,
    parameter int DELAY_WIDTH = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dreq_in,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic                         dack_out,
    output logic                         dreq_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    input  logic                         dack_in,
    input  logic [DELAY_WIDTH-1:0]       delay_cfg,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {IN_IDLE, IN_ACK} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT} out_state_t;

    logic s_dreq_in;
    logic s_dack_in;

    in_state_t  in_state_q, in_state_d;
    out_state_t out_state_q, out_state_d;
    logic                  dack_q, dack_d;
    logic                  dreq_q, dreq_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push;
    logic                  pop;
    logic                  head_ready;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DELAY_WIDTH-1:0] age_q [DEPTH];

    // Handshake inputs cross in from another timing domain; SYNC_STAGES=0 means
    // the producer/consumer already share this clock.
    if (SYNC_STAGES == 0) begin : g_nosync
        assign s_dreq_in = dreq_in;
        assign s_dack_in = dack_in;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] dreq_sync_q;
        logic [SYNC_STAGES-1:0] dack_sync_q;

        // Shift chains for the two incoming handshake wires.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dreq_sync_q <= '0;
                dack_sync_q <= '0;
            end else begin
                dreq_sync_q[0] <= dreq_in;
                dack_sync_q[0] <= dack_in;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    dreq_sync_q[i] <= dreq_sync_q[i-1];
                    dack_sync_q[i] <= dack_sync_q[i-1];
                end
            end
        end

        assign s_dreq_in = dreq_sync_q[SYNC_STAGES-1];
        assign s_dack_in = dack_sync_q[SYNC_STAGES-1];
    end

    // Input FSM: capture on request when space is available, then wait for
    // the request to return to zero.
    always_comb begin
        in_state_d = in_state_q;
        dack_d     = dack_q;
        push       = 1'b0;
        case (in_state_q)
            IN_IDLE: begin
                if (s_dreq_in && (count_q < FULL_CNT)) begin
                    push       = 1'b1;
                    dack_d     = 1'b1;
                    in_state_d = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!s_dreq_in) begin
                    dack_d     = 1'b0;
                    in_state_d = IN_IDLE;
                end
            end
            default: in_state_d = IN_IDLE;
        endcase
    end

    // Head is eligible only after its dwell time has fully elapsed. Using the
    // registered count keeps a just-captured token from being presented in the
    // same cycle it is written.
    assign head_ready = (count_q != '0) && (age_q[head_q] == '0);

    // Output FSM: present the head token, pop it on acknowledge, then wait for
    // the acknowledge to return to zero.
    always_comb begin
        out_state_d = out_state_q;
        dreq_d      = dreq_q;
        dout_d      = dout_q;
        pop         = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (head_ready) begin
                    dout_d      = mem_q[head_q];
                    dreq_d      = 1'b1;
                    out_state_d = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (s_dack_in) begin
                    dreq_d      = 1'b0;
                    pop         = 1'b1;
                    out_state_d = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (!s_dack_in) begin
                    out_state_d = OUT_IDLE;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    // Pointer wrap and occupancy bookkeeping; a push and pop in the same cycle
    // leave the count unchanged while both pointers advance.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
        end
        if (push) begin
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_IDLE;
            dack_q      <= 1'b0;
            dreq_q      <= 1'b0;
            dout_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            dack_q      <= dack_d;
            dreq_q      <= dreq_d;
            dout_q      <= dout_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // Token storage with saturating age counters. Free entries may also count
    // down harmlessly: they are reloaded from delay_cfg when next written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (age_q[i] != '0) begin
                    age_q[i] <= age_q[i] - DELAY_WIDTH'(1);
                end
            end
            if (push) begin
                mem_q[tail_q] <= data_in;
                age_q[tail_q] <= delay_cfg;
            end
        end
    end

    assign dack_out = dack_q;
    assign dreq_out = dreq_q;
    assign data_out = dout_q;
    assign count    = count_q;

endmodule
